sample_capture_buffer: RTL and testbench
========================================

# sample_capture_buffer

Parametrised pre-trigger capture buffer for the sample path. Writes an incoming sample stream into a circular on-chip RAM once armed. Freezes a window of exactly 2^ADDR_W samples around a trigger event, with a programmable number of pre-trigger samples. Replays the window oldest-first through a one-sample-per-request read port. Sits between the sample source and the readout/host interface, replacing the bare sample RAM where trigger-aligned capture is needed.

## Interface

- DATA_W, 16, sample width in bits
- ADDR_W, 8, address width; DEPTH = 2^ADDR_W samples
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- arm  in  1  start a capture; accepted in IDLE, DONE or READ
- abort  in  1  return to IDLE from any state
- pretrig  in  ADDR_W  pre-trigger sample count; sampled when arm is accepted
- in_valid  in  1  in_data valid this cycle
- in_data  in  DATA_W  sample
- trig  in  1  trigger qualifier; meaningful only with in_valid=1
- rd_req  in  1  request next stored sample
- rd_valid  out  1  rd_data valid; one-cycle pulse per accepted rd_req
- rd_data  out  DATA_W  read sample, registered
- rd_last  out  1  with rd_valid; marks the final (DEPTH-th) sample
- busy  out  1  high in PRE, ARMED, POST
- triggered  out  1  high in POST
- done  out  1  high in DONE and READ

## Operation

- States:
  - IDLE: nothing written.
  - PRE: fills pre-trigger region.
  - ARMED: circular write, waiting for trig.
  - POST: post-trigger fill.
  - DONE: frozen, idle read port.
  - READ: readout in progress.
- Write rule: in PRE/ARMED/POST, each in_valid=1 cycle writes in_data at wr_ptr; wr_ptr increments mod DEPTH. in_valid is ignored in other states.
- arm accepted:
  - wr_ptr is cleared to 0 and pretrig is latched as P.
  - Next state is PRE if P>0, else ARMED.
  - Any stored data is discarded.
- PRE: counts written samples. After the P-th write, the next state is ARMED. trig is ignored in PRE.
- ARMED: a cycle with in_valid=1 and trig=1 writes the trigger sample and moves to POST.
  - The trigger sample counts as post-sample 1.
  - trig with in_valid=0 is ignored.
- POST: captures DEPTH-P samples in total, including the trigger sample. After the final write, the next state is DONE.
- DONE/READ readout:
  - rd_ptr starts at the wr_ptr value at DONE entry, which addresses the oldest sample.
  - Each rd_req reads rd_ptr; rd_ptr increments mod DEPTH.
  - The first rd_req moves DONE to READ.
  - After the DEPTH-th read is issued, the next state is IDLE.
- Window content: P samples preceding the trigger, then the trigger sample, then DEPTH-P-1 following samples.
- rd_req outside DONE/READ is ignored: no rd_valid, no pointer change.
- abort:
  - Next state is IDLE, with no further writes and no rd_valid for reads not yet issued.
  - abort and arm in the same cycle: abort wins.
- arm during PRE/ARMED/POST is ignored. arm in DONE/READ restarts capture and abandons readout.
- Counters are ADDR_W+1 bits where a full-DEPTH count is needed; pointers are ADDR_W bits and wrap naturally.

## Timing

- Reset: state IDLE, wr_ptr=rd_ptr=0. rd_valid, rd_data, rd_last, busy, triggered and done are all 0 while rst_n=0.
- arm at edge N: busy=1 from cycle N+1. A sample with in_valid at N+1 is the first write.
- The POST final write at edge N gives triggered=0 and done=1 from cycle N+1. rd_req is accepted from N+1.
- Read latency is 1 cycle: rd_req at edge N gives rd_valid, rd_data and rd_last valid during cycle N+1, for one cycle.
- Back-to-back rd_req (every cycle) is supported at full rate.
- Status outputs are registered from state and change the cycle after the transition edge.
- rst_n deassertion is synchronised internally before state leaves IDLE.

## Test plan

- **Basic ramp:** ADDR_W=4, P=4. After arm, stream in_data=n (n=0,1,…) every cycle, with trig on sample 0x0014. 16 back-to-back rd_req → rd_data 0x0010…0x001F, rd_last only on 0x001F, done drops after the last read.
- **Zero pre-trigger:** P=0, trig with sample 0 → state goes straight to ARMED. Readout is 0x0000…0x000F.
- **Trigger masking:** P=4, trig on samples 1 and 6, plus trig with in_valid=0 at some cycle → trigger taken at sample 6. Readout is 0x0002…0x0011.
- **Gapped input:** in_valid every 3rd cycle → identical readout to the Basic ramp case. busy=1 throughout capture.
- **Abort:** abort during POST → busy=0 and done=0 next cycle. Later rd_req gives no rd_valid. A re-arm captures correctly.
- **Reset mid-READ:** assert rst_n=0 after 5 reads → all outputs 0 immediately. Release, re-arm, repeat the Basic ramp case → passes.

Source files
------------

// File: rtl/sample_capture_buffer_if.sv
// Control, sample-input and readout signals of sample_capture_buffer.
// The master side drives capture control and samples; the slave side is the buffer.
interface sample_capture_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              arm;
  logic              abort;
  logic [ADDR_W-1:0] pretrig;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              trig;
  logic              rd_req;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              triggered;
  logic              done;

  modport master (
    output arm, abort, pretrig, in_valid, in_data, trig, rd_req,
    input  rd_valid, rd_data, rd_last, busy, triggered, done
  );

  modport slave (
    input  arm, abort, pretrig, in_valid, in_data, trig, rd_req,
    output rd_valid, rd_data, rd_last, busy, triggered, done
  );
endinterface

// File: rtl/sample_capture_buffer.sv
// Pre-trigger capture buffer: circular sample RAM that freezes a 2^ADDR_W window
// around a trigger and replays it oldest-first, one sample per rd_req.
module sample_capture_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sample_capture_buffer_if.slave bus
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_RD = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE, READ} state_t;

  state_t            state, next_state;
  logic [1:0]        rst_sync;
  logic              run;
  logic              capturing, readable, arm_ok, wr_en, rd_en;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, p_q;
  logic [ADDR_W:0]   post_cnt, rd_cnt, post_total;
  logic              busy_d, triggered_d, done_d;
  logic              busy_q, triggered_q, done_q;
  logic              rd_valid_q, rd_last_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign capturing  = (state == PRE) || (state == ARMED) || (state == POST);
  assign readable   = (state == DONE) || (state == READ);
  assign arm_ok     = run && !bus.abort && bus.arm && ((state == IDLE) || readable);
  assign wr_en      = run && !bus.abort && bus.in_valid && capturing;
  assign rd_en      = run && !bus.abort && !bus.arm && bus.rd_req && readable;
  assign post_total = (ADDR_W+1)'(DEPTH) - {1'b0, p_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= next_state;
      busy_q      <= busy_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    next_state = state;
    if (!run || bus.abort) begin
      next_state = IDLE;
    end else if (arm_ok) begin
      next_state = (bus.pretrig != '0) ? PRE : ARMED;
    end else begin
      unique case (state)
        PRE:     if (wr_en && (wr_ptr == p_q - 1'b1)) next_state = ARMED;
        ARMED:   if (wr_en && bus.trig) next_state = (post_total == CNT_ONE) ? DONE : POST;
        POST:    if (wr_en && (post_cnt + 1'b1 == post_total)) next_state = DONE;
        DONE:    if (rd_en) next_state = READ;
        READ:    if (rd_en && (rd_cnt == LAST_RD)) next_state = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_d      = (next_state == PRE) || (next_state == ARMED) || (next_state == POST);
    triggered_d = (next_state == POST);
    done_d      = (next_state == DONE) || (next_state == READ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      p_q      <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
    end else begin
      if (arm_ok) begin
        wr_ptr <= '0;
        p_q    <= bus.pretrig;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // While ARMED this parks at 1 so the trigger sample is post-sample 1.
      if (wr_en && (state == ARMED))     post_cnt <= CNT_ONE;
      else if (wr_en && (state == POST)) post_cnt <= post_cnt + 1'b1;
      // The slot after the final write holds the oldest sample of the frozen window.
      if (wr_en && (next_state == DONE)) begin
        rd_ptr <= wr_ptr + 1'b1;
        rd_cnt <= '0;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // NOTE: the sample RAM is not reset; no slot is read before the capture that fills it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_last_q  <= rd_en && (rd_cnt == LAST_RD);
      if (rd_en) rd_data_q <= mem[rd_ptr];
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.busy      = busy_q;
  assign bus.triggered = triggered_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_sample_capture_buffer.sv
// Self-checking bench for sample_capture_buffer: directed test-plan cases plus random
// captures, all checked against a stream-log model of the trigger window.
module tb_sample_capture_buffer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: every sample accepted since arm, the trigger's index in that
  // stream, and the pre-trigger count. The window is log_q[trig_idx-p_m +: DEPTH].
  int                p_m;
  int                trig_idx;
  bit                capturing_m;
  logic [DATA_W-1:0] log_q[$];

  sample_capture_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sample_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit complete_m();
    return (trig_idx >= 0) && (log_q.size() >= trig_idx + DEPTH - p_m);
  endfunction

  function automatic logic [DATA_W-1:0] window_m(input int k);
    return log_q[trig_idx - p_m + k];
  endfunction

  task automatic check_status(input string tag);
    bit cpl;
    cpl = complete_m();
    check({tag, "_busy"},      bus.busy,      capturing_m && !cpl);
    check({tag, "_triggered"}, bus.triggered, capturing_m && (trig_idx >= 0) && !cpl);
    check({tag, "_done"},      bus.done,      capturing_m && cpl);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_valid"},  bus.rd_valid,  0);
    check({tag, "_rd_data"},   bus.rd_data,   0);
    check({tag, "_rd_last"},   bus.rd_last,   0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_triggered"}, bus.triggered, 0);
    check({tag, "_done"},      bus.done,      0);
  endtask

  task automatic do_arm(input int p);
    bus.arm      = 1'b1;
    bus.pretrig  = ADDR_W'(p);
    bus.in_valid = 1'b0;
    bus.trig     = 1'b0;
    bus.rd_req   = 1'b0;
    @(negedge clk);
    bus.arm     = 1'b0;
    p_m         = p;
    trig_idx    = -1;
    capturing_m = 1'b1;
    log_q.delete();
    check_status("arm");
  endtask

  // One input cycle; the model logs what the buffer should have accepted on that edge.
  task automatic feed(input logic [DATA_W-1:0] data, input bit valid, input bit tg);
    bus.in_data  = data;
    bus.in_valid = valid;
    bus.trig     = tg;
    @(negedge clk);
    if (capturing_m && valid && !complete_m()) begin
      if ((trig_idx < 0) && tg && (log_q.size() >= p_m)) trig_idx = log_q.size();
      log_q.push_back(data);
    end
    check_status("cap");
  endtask

  // Directed: sample n carries data n, trig on n==t1 or n==t2, gap-1 idle cycles
  // (with trig=1, in_valid=0) before each sample. Random: data, trig and gaps random.
  task automatic stream(input int t1, input int t2, input int gap, input bit rnd, input int max_n);
    int n;
    int cyc;
    int g;
    n   = 0;
    cyc = 0;
    while (!complete_m() && (n < max_n) && (cyc < 1000)) begin
      g = rnd ? int'($urandom_range(1, 3)) : gap;
      for (int i = 1; i < g; i++) begin
        feed(DATA_W'($urandom), 1'b0, 1'b1);
        cyc++;
      end
      if (rnd) feed(DATA_W'($urandom), 1'b1, $urandom_range(0, 7) == 0);
      else     feed(DATA_W'(n), 1'b1, (n == t1) || (n == t2));
      n++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.trig     = 1'b0;
  endtask

  task automatic read_window(input bit gaps, input int nreads);
    int k;
    int cyc;
    bit req;
    k   = 0;
    cyc = 0;
    bus.in_valid = 1'b0;
    bus.trig     = 1'b0;
    while ((k < nreads) && (cyc < 200)) begin
      req = !gaps || ($urandom_range(0, 2) != 0);
      bus.rd_req = req;
      @(negedge clk);
      cyc++;
      check("rd_valid", bus.rd_valid, req);
      if (req) begin
        check("rd_data", bus.rd_data, window_m(k));
        check("rd_last", bus.rd_last, k == DEPTH - 1);
        k++;
      end
      check("rd_done", bus.done, k < DEPTH);
    end
    bus.rd_req = 1'b0;
    if (k >= DEPTH) capturing_m = 1'b0;
  endtask

  task automatic capture_and_read(input int p, input int t1, input int t2, input int gap);
    do_arm(p);
    stream(t1, t2, gap, 1'b0, 1000);
    read_window(1'b0, DEPTH);
    @(negedge clk);
    check_status("after_read");
    check("after_read_rd_valid", bus.rd_valid, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.arm      = 1'b0;
    bus.abort    = 1'b0;
    bus.pretrig  = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.trig     = 1'b0;
    bus.rd_req   = 1'b0;
    capturing_m  = 1'b0;
    trig_idx     = -1;
    p_m          = 0;
    #1;
    check_reset("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic ramp: P=4, trigger on 0x14, window 0x10..0x1F.
    capture_and_read(4, 'h14, -1, 1);
    // Zero pre-trigger: trigger on sample 0, window 0x00..0x0F.
    capture_and_read(0, 0, -1, 1);
    // Trigger masking: trig in PRE and with in_valid=0 ignored, window 0x02..0x11.
    capture_and_read(4, 1, 6, 2);
    // Gapped input: one sample every third cycle, same window as the basic ramp.
    capture_and_read(4, 'h14, -1, 3);
    // Largest pre-trigger count: the trigger sample is the last one written.
    capture_and_read(DEPTH - 1, 'h14, -1, 1);

    // Abort during POST, reads afterwards are ignored, then a clean re-capture.
    do_arm(4);
    stream('h14, -1, 1, 1'b0, 'h17);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    capturing_m  = 1'b0;
    check_status("abort");
    repeat (3) begin
      bus.rd_req = 1'b1;
      @(negedge clk);
      check("abort_rd_valid", bus.rd_valid, 0);
    end
    bus.rd_req = 1'b0;
    capture_and_read(4, 'h14, -1, 1);

    // Reset in the middle of a readout, then the basic ramp again.
    do_arm(4);
    stream('h14, -1, 1, 1'b0, 1000);
    read_window(1'b0, 5);
    rst_n = 1'b0;
    #1;
    check_reset("mid_read_reset");
    capturing_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    capture_and_read(4, 'h14, -1, 1);

    // Random pre-trigger counts, data, triggers, input gaps and read gaps.
    for (int r = 0; r < 6; r++) begin
      do_arm(int'($urandom_range(0, DEPTH - 1)));
      stream(-1, -1, 1, 1'b1, 1000);
      read_window(1'b1, DEPTH);
      @(negedge clk);
      check_status("rnd_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
